wt_wbuf_coalesce: RTL and testbench

Parametrised store write buffer for the write-through data cache. It generalises the fixed two-entry write buffer to configurable depth, data width and outstanding-store limit. It adds byte-merging of back-to-back cacheable stores to the same word and out-of-order completion by transaction ID. It sits between the store unit and the memory-side NoC adapter, and also provides a load-collision check to the load unit.

---
 rtl/wt_wbuf_coalesce.sv | 101 ++++++++++
 tb/tb_wt_wbuf_coalesce.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_wbuf_coalesce.sv
// wt_wbuf_coalesce: write-through store buffer with byte merging into the newest
// unissued entry and out-of-order completion keyed by entry index (TID)
module wt_wbuf_coalesce #(
  parameter int DEPTH           = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 7,
  parameter int TID_WIDTH       = $clog2(DEPTH)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic [ADDR_WIDTH-1:0]                  req_addr_i,
  input  logic [DATA_WIDTH-1:0]                  req_data_i,
  input  logic [DATA_WIDTH/8-1:0]                req_be_i,
  input  logic                                   req_nc_i,
  output logic                                   mem_valid_o,
  input  logic                                   mem_ready_i,
  output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
  output logic [DATA_WIDTH-1:0]                  mem_data_o,
  output logic [DATA_WIDTH/8-1:0]                mem_be_o,
  output logic [TID_WIDTH-1:0]                   mem_tid_o,
  input  logic                                   ack_valid_i,
  input  logic [TID_WIDTH-1:0]                   ack_tid_i,
  input  logic [ADDR_WIDTH-1:0]                  ld_addr_i,
  output logic                                   ld_hit_o,
  output logic                                   empty_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);
  localparam int BW = DATA_WIDTH/8;
  localparam int OB = $clog2(BW);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int WW = ADDR_WIDTH-OB;
  typedef enum logic [1:0] {FREE, VALID, SENT} state_t;
  state_t              st  [DEPTH];
  logic [WW-1:0]       wa  [DEPTH];
  logic [DATA_WIDTH-1:0] dat [DEPTH];
  logic [BW-1:0]       be  [DEPTH];
  logic                nc  [DEPTH];
  logic [TID_WIDTH-1:0] head, tail, last;
  logic [OW-1:0]       cnt;
  logic [WW-1:0]       req_wa;
  logic                merge, accept, issue, ack_ok;
  assign req_wa        = req_addr_i[ADDR_WIDTH-1:OB];
  assign last          = tail - TID_WIDTH'(1);
  assign mem_valid_o   = st[head] == VALID && cnt < OW'(MAX_OUTSTANDING);
  assign mem_addr_o    = {wa[head], {OB{1'b0}}};
  assign mem_data_o    = dat[head];
  assign mem_be_o      = be[head];
  assign mem_tid_o     = head;
  assign outstanding_o = cnt;
  // never merge into the entry being presented, so its fields stay stable
  assign merge  = !req_nc_i && st[last] == VALID && !nc[last] && wa[last] == req_wa &&
                  !(mem_valid_o && head == last);
  assign req_ready_o = merge || st[tail] == FREE;
  assign accept = req_valid_i && req_ready_o;
  assign issue  = mem_valid_o && mem_ready_i;
  assign ack_ok = ack_valid_i && st[ack_tid_i] == SENT;
  always_comb begin
    ld_hit_o = 1'b0;
    empty_o  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_hit_o = ld_hit_o | (st[i] != FREE && wa[i] == ld_addr_i[ADDR_WIDTH-1:OB]);
      empty_o  = empty_o & (st[i] == FREE);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        st[i]  <= FREE;
        wa[i]  <= '0;
        dat[i] <= '0;
        be[i]  <= '0;
        nc[i]  <= 1'b0;
      end
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (ack_ok) st[ack_tid_i] <= FREE;
      if (issue) begin
        st[head] <= SENT;
        head     <= head + TID_WIDTH'(1);
      end
      if (accept && merge) begin
        for (int b = 0; b < BW; b++)
          if (req_be_i[b]) dat[last][8*b +: 8] <= req_data_i[8*b +: 8];
        be[last] <= be[last] | req_be_i;
      end else if (accept) begin
        st[tail]  <= VALID;
        wa[tail]  <= req_wa;
        dat[tail] <= req_data_i;
        be[tail]  <= req_be_i;
        nc[tail]  <= req_nc_i;
        tail      <= tail + TID_WIDTH'(1);
      end
      cnt <= cnt + OW'(issue) - OW'(ack_ok);
    end
  end
endmodule

// File: tb/tb_wt_wbuf_coalesce.sv
// tb_wt_wbuf_coalesce: directed scenarios plus random traffic checked every cycle
// against a queue-based model of pending stores and a set of in-flight TIDs
module tb_wt_wbuf_coalesce;
  localparam int DEPTH = 8;
  localparam int MO    = 7;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid, req_ready, req_nc;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_be;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_data;
  logic [3:0]  mem_be;
  logic [2:0]  mem_tid;
  logic        ack_valid;
  logic [2:0]  ack_tid;
  logic [31:0] ld_addr;
  logic        ld_hit, empty;
  logic [2:0]  outstanding;
  int total = 0, passed = 0;
  always #10 clk = ~clk;

  wt_wbuf_coalesce #(.DEPTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(7), .TID_WIDTH(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_be_i(req_be), .req_nc_i(req_nc),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_be_o(mem_be), .mem_tid_o(mem_tid),
    .ack_valid_i(ack_valid), .ack_tid_i(ack_tid), .ld_addr_i(ld_addr),
    .ld_hit_o(ld_hit), .empty_o(empty), .outstanding_o(outstanding));

  typedef struct {int tid; logic [31:0] wa; logic [31:0] d; logic [3:0] be; bit nc;} ent_t;
  ent_t        pend[$];
  bit          sent_v[DEPTH];
  logic [31:0] sent_a[DEPTH];
  int          nxt;
  bit          e_mv, e_rdy, e_merge;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int n_sent();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(sent_v[i]);
    return n;
  endfunction

  function automatic bit slot_free(int s);
    if (sent_v[s]) return 1'b0;
    foreach (pend[i]) if (pend[i].tid == s) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_hit(logic [31:0] a);
    foreach (pend[i]) if (pend[i].wa == (a & ~32'h3)) return 1'b1;
    for (int i = 0; i < DEPTH; i++) if (sent_v[i] && sent_a[i] == (a & ~32'h3)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mask32(logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < DEPTH; i++) sent_v[i] = 1'b0;
    nxt = 0;
  endtask

  task automatic model_check();
    e_mv    = pend.size() > 0 && n_sent() < MO;
    e_merge = pend.size() > 0 && !req_nc && !pend[pend.size()-1].nc &&
              pend[pend.size()-1].wa == (req_addr & ~32'h3) && !(e_mv && pend.size() == 1);
    e_rdy   = e_merge || slot_free(nxt);
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("mem_valid", 32'(mem_valid), 32'(e_mv));
    chk("ld_hit", 32'(ld_hit), 32'(exp_hit(ld_addr)));
    chk("empty", 32'(empty), 32'(pend.size() == 0 && n_sent() == 0));
    chk("outstanding", 32'(outstanding), 32'(n_sent()));
    if (e_mv) begin
      chk("mem_addr", mem_addr, pend[0].wa);
      chk("mem_tid", 32'(mem_tid), 32'(pend[0].tid));
      chk("mem_be", 32'(mem_be), 32'(pend[0].be));
      chk("mem_data", mem_data & mask32(pend[0].be), pend[0].d & mask32(pend[0].be));
    end
  endtask

  task automatic model_update();
    ent_t t;
    if (ack_valid && sent_v[ack_tid]) sent_v[ack_tid] = 1'b0;
    if (req_valid && e_rdy) begin
      if (e_merge) begin
        t = pend[pend.size()-1];
        for (int b = 0; b < 4; b++) if (req_be[b]) t.d[8*b +: 8] = req_data[8*b +: 8];
        t.be = t.be | req_be;
        pend[pend.size()-1] = t;
      end else begin
        t = '{nxt, req_addr & ~32'h3, req_data, req_be, req_nc};
        pend.push_back(t);
        nxt = (nxt + 1) % DEPTH;
      end
    end
    if (e_mv && mem_ready) begin
      sent_v[pend[0].tid] = 1'b1;
      sent_a[pend[0].tid] = pend[0].wa;
      void'(pend.pop_front());
    end
  endtask

  task automatic idle();
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_be = '0; req_nc = 1'b0;
    mem_ready = 1'b0; ack_valid = 1'b0; ack_tid = '0;
  endtask

  task automatic step(bit v, logic [31:0] a, logic [31:0] d, logic [3:0] be, bit nc,
                      bit mr, bit av, logic [2:0] at);
    req_valid = v; req_addr = a; req_data = d; req_be = be; req_nc = nc;
    mem_ready = mr; ack_valid = av; ack_tid = at;
    #1 model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle();
    #1;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] be, bit nc = 1'b0, bit mr = 1'b0);
    step(1'b1, a, d, be, nc, mr, 1'b0, 3'd0);
  endtask

  task automatic cyc(bit mr, bit av = 1'b0, logic [2:0] at = 3'd0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, mr, av, at);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_ld_hit", 32'(ld_hit), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((pend.size() > 0 || n_sent() > 0) && n < 100) begin
      int t = -1;
      for (int i = 0; i < DEPTH; i++) if (sent_v[i] && t < 0) t = i;
      cyc(1'b1, t >= 0, 3'(t < 0 ? 0 : t));
      n++;
    end
    chk("drain_bound", 32'(n < 100), 32'd1);
  endtask

  initial begin
    idle();
    ld_addr = '0;
    do_reset();
    // merge blocked while the target is the presented head
    wr(32'h80000000, 32'h0000BEEF, 4'h3);
    chk("lat1_valid", 32'(mem_valid), 32'd1);
    chk("lat1_tid", 32'(mem_tid), 32'd0);
    wr(32'h80000002, 32'hCAFE0000, 4'hC);
    chk("blocked_be", 32'(mem_be), 32'h3);
    cyc(1'b1);
    chk("blocked_tid", 32'(mem_tid), 32'd1);
    chk("blocked_be2", 32'(mem_be), 32'hC);
    cyc(1'b1);
    chk("two_out", 32'(outstanding), 32'd2);
    cyc(1'b0, 1'b1, 3'd0);
    cyc(1'b0, 1'b1, 3'd1);
    chk("empty_after_acks", 32'(empty), 32'd1);
    // merge succeeds with a store queued ahead
    wr(32'h80000040, 32'h11111111, 4'hF);
    wr(32'h80000000, 32'h0000BEEF, 4'h3);
    wr(32'h80000002, 32'hCAFE0000, 4'hC);
    cyc(1'b1);
    chk("merged_tid", 32'(mem_tid), 32'd3);
    chk("merged_data", mem_data, 32'hCAFEBEEF);
    chk("merged_be", 32'(mem_be), 32'hF);
    cyc(1'b1);
    chk("merged_single", 32'(mem_valid), 32'd0);
    cyc(1'b0, 1'b1, 3'd2);
    cyc(1'b0, 1'b1, 3'd3);
    // load collision
    wr(32'h80000104, 32'h12345678, 4'hF);
    ld_addr = 32'h80000106; #1;
    chk("ld_hit_same", 32'(ld_hit), 32'd1);
    ld_addr = 32'h80000108; #1;
    chk("ld_hit_other", 32'(ld_hit), 32'd0);
    cyc(1'b1);
    cyc(1'b0, 1'b1, 3'd4);
    ld_addr = 32'h80000106; #1;
    chk("ld_hit_acked", 32'(ld_hit), 32'd0);
    // reset with work in flight; stale ack afterwards is ignored
    wr(32'h80000200, 32'hA5A5A5A5, 4'hF);
    cyc(1'b1);
    wr(32'h80000300, 32'h5A5A5A5A, 4'hF);
    do_reset();
    cyc(1'b0, 1'b1, 3'd5);
    chk("stale_ack", 32'(outstanding), 32'd0);
    // nc stores never merge
    wr(32'h10000000, 32'h1, 4'hF, 1'b1);
    wr(32'h10000000, 32'h2, 4'hF, 1'b1);
    chk("nc_tid0", 32'(mem_tid), 32'd0);
    cyc(1'b1);
    chk("nc_tid1", 32'(mem_tid), 32'd1);
    chk("nc_data1", mem_data, 32'h2);
    cyc(1'b1);
    drain();
    // full buffer
    for (int i = 0; i < 8; i++) wr(32'h80001000 + 32'(16*i), 32'(i), 4'hF);
    req_valid = 1'b1; req_addr = 32'h80002000; req_be = 4'hF; #1;
    chk("full_ready", 32'(req_ready), 32'd0);
    idle();
    cyc(1'b1);
    cyc(1'b0, 1'b1, 3'd2);
    req_valid = 1'b1; req_addr = 32'h80002000; req_be = 4'hF; #1;
    chk("refree_ready", 32'(req_ready), 32'd1);
    idle();
    drain();
    // outstanding limit
    do_reset();
    for (int i = 0; i < 8; i++) wr(32'h80003000 + 32'(16*i), 32'(i), 4'hF);
    for (int i = 0; i < 8; i++) cyc(1'b1);
    chk("limit_valid", 32'(mem_valid), 32'd0);
    chk("limit_out", 32'(outstanding), 32'd7);
    cyc(1'b0, 1'b1, 3'd3);
    chk("limit_resume", 32'(mem_valid), 32'd1);
    chk("limit_tid", 32'(mem_tid), 32'd7);
    cyc(1'b1);
    chk("limit_out2", 32'(outstanding), 32'd7);
    drain();
    // out-of-order acks
    wr(32'h80004000, 32'h1, 4'hF, 1'b0, 1'b1);
    wr(32'h80004010, 32'h2, 4'hF, 1'b0, 1'b1);
    wr(32'h80004020, 32'h3, 4'hF, 1'b0, 1'b1);
    cyc(1'b1);
    cyc(1'b0, 1'b1, 3'd2);
    cyc(1'b0, 1'b1, 3'd0);
    cyc(1'b0, 1'b1, 3'd1);
    chk("ooo_empty", 32'(empty), 32'd1);
    chk("ooo_out", 32'(outstanding), 32'd0);
    // random traffic
    for (int c = 0; c < 600; c++) begin
      int s[$];
      bit av;
      int at;
      for (int i = 0; i < DEPTH; i++) if (sent_v[i]) s.push_back(i);
      av = s.size() > 0 && $urandom_range(0, 2) != 0;
      at = av ? s[$urandom_range(0, s.size()-1)] : 0;
      ld_addr = 32'h80000000 + 32'(4*$urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)),
           32'h80000000 + 32'(4*$urandom_range(0, 5)) + 32'($urandom_range(0, 3)),
           $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) != 0, av, 3'(at));
    end
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
